// File: rtl/sdram_stream_test_ctrl_pkg.sv
// Shared types and constants for the SDRAM stream test sequencer.
// Covers the FSM encoding, the checker timing constants and the pattern half-select helper.
package sdram_stream_test_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int WORD_W     = 16;
  // Cycles between a word reaching the checker and its error flag becoming valid
  localparam int CHK_LAT    = 2;
  // Words the checker needs before its error flag means anything
  localparam int QUAL_WORDS = 4;

  function automatic logic [WORD_W-1:0] pattern_half(input logic [31:0] value, input logic low_half);
    return low_half ? value[15:0] : value[31:16];
  endfunction

endpackage

// File: rtl/sdram_stream_test_ctrl_if.sv
// Word-wide write and read ports between the test sequencer and the SDRAM controller.
// The sequencer is the master; the memory side is the slave.
interface sdram_stream_test_ctrl_if
  import sdram_stream_test_ctrl_pkg::*;
#(
  parameter int ADDR_W = 22
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              rd_req;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [WORD_W-1:0] rd_data;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_req, rd_addr,
    input  wr_ready, rd_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_req, rd_addr,
    output wr_ready, rd_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/sdram_stream_test_ctrl_pattern_gen.sv
// Incrementing 32-bit pattern source, emitted as 16-bit words high half first.
// The counter survives across passes and runs; only reset clears it.
module stream_pattern_gen
  import sdram_stream_test_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  output logic [WORD_W-1:0] word
);
  logic [31:0] cnt_reg;
  logic [31:0] cnt_next;
  logic        half_reg;
  logic        half_next;

  always_comb begin
    cnt_next  = cnt_reg;
    half_next = half_reg;
    if (advance) begin
      half_next = ~half_reg;
      if (half_reg) begin
        cnt_next = cnt_reg + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      half_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      half_reg <= half_next;
    end
  end

  assign word = pattern_half(cnt_reg, half_reg);

endmodule

// File: rtl/sdram_stream_test_ctrl.sv
// SDRAM stream test sequencer: writes a counter burst, reads it back, feeds the checker,
// and tracks errors, read timeouts and completed passes in single-shot or loop mode.
module sdram_stream_test_ctrl
  import sdram_stream_test_ctrl_pkg::*;
#(
  parameter int BURST_WORDS = 256,
  parameter int ADDR_W      = 22,
  parameter int TIMEOUT     = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     loop,
  input  logic                     stop,
  sdram_stream_test_ctrl_if.master mem,
  output logic                     chk_wren,
  output logic [WORD_W-1:0]        chk_data,
  input  logic                     chk_err,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     timeout,
  output logic [31:0]              pass_cnt
);
  localparam int IDX_W = $clog2(BURST_WORDS + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BURST_WORDS - 1);
  localparam logic [IDX_W-1:0] BURST_IDX = IDX_W'(BURST_WORDS);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [2:0]       QUAL_CNT  = 3'(QUAL_WORDS);
  localparam logic [1:0]       LAT_CNT   = 2'(CHK_LAT);
  localparam logic [1:0]       CHK_LAST  = 2'(CHK_LAT - 1);

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  wr_idx_reg, wr_idx_next;
  logic [IDX_W-1:0]  rd_cmd_reg, rd_cmd_next;
  logic [IDX_W-1:0]  rd_rcv_reg, rd_rcv_next;
  logic [1:0]        chk_cyc_reg, chk_cyc_next;
  logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
  logic [2:0]        fwd_cnt_reg, fwd_cnt_next;
  logic [1:0]        qual_dly_reg, qual_dly_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic              loop_reg, loop_next;
  logic              stop_reg, stop_next;
  logic              err_reg, err_next;
  logic              timeout_reg, timeout_next;
  logic [31:0]       pass_cnt_reg, pass_cnt_next;
  logic              chk_wren_reg;
  logic [WORD_W-1:0] chk_data_reg;

  logic              wr_fire;
  logic              rd_req_int;
  logic              rd_fire;
  logic              rd_take;
  logic              qualified;
  logic              err_set;
  logic [WORD_W-1:0] pattern_word;

  assign wr_fire    = (state_reg == ST_WRITE) && mem.wr_ready;
  assign rd_req_int = (state_reg == ST_READ) && (rd_cmd_reg != BURST_IDX);
  assign rd_fire    = rd_req_int && mem.rd_ready;
  assign rd_take    = (state_reg == ST_READ) && mem.rd_valid;
  assign qualified  = (fwd_cnt_reg == QUAL_CNT) && (qual_dly_reg == LAT_CNT);
  assign err_set    = qualified && chk_err && ((state_reg == ST_READ) || (state_reg == ST_CHECK));

  stream_pattern_gen u_pattern (
    .clk     (clk),
    .rst     (rst),
    .advance (wr_fire),
    .word    (pattern_word)
  );

  always_comb begin
    state_next    = state_reg;
    wr_idx_next   = wr_idx_reg;
    rd_cmd_next   = rd_cmd_reg;
    rd_rcv_next   = rd_rcv_reg;
    chk_cyc_next  = chk_cyc_reg;
    to_cnt_next   = to_cnt_reg;
    fwd_cnt_next  = fwd_cnt_reg;
    qual_dly_next = qual_dly_reg;
    base_next     = base_reg;
    loop_next     = loop_reg;
    stop_next     = stop_reg | stop;
    err_next      = err_reg | err_set;
    timeout_next  = timeout_reg;
    pass_cnt_next = pass_cnt_reg;

    // Qualification window: count forwarded words, then let the checker settle
    if (chk_wren_reg && (fwd_cnt_reg != QUAL_CNT)) begin
      fwd_cnt_next = fwd_cnt_reg + 3'd1;
    end
    if ((fwd_cnt_reg == QUAL_CNT) && (qual_dly_reg != LAT_CNT)) begin
      qual_dly_next = qual_dly_reg + 2'd1;
    end

    case (state_reg)
      ST_IDLE: begin
        stop_next = 1'b0;
        if (start) begin
          state_next    = ST_WRITE;
          loop_next     = loop & ~stop;
          err_next      = 1'b0;
          timeout_next  = 1'b0;
          pass_cnt_next = '0;
          wr_idx_next   = '0;
          fwd_cnt_next  = '0;
          qual_dly_next = '0;
        end
      end
      ST_WRITE: begin
        if (wr_fire) begin
          if (wr_idx_reg == LAST_IDX) begin
            state_next  = ST_READ;
            wr_idx_next = '0;
            rd_cmd_next = '0;
            rd_rcv_next = '0;
            to_cnt_next = '0;
          end else begin
            wr_idx_next = wr_idx_reg + 1'b1;
          end
        end
      end
      ST_READ: begin
        if (rd_fire) begin
          rd_cmd_next = rd_cmd_reg + 1'b1;
        end
        if (mem.rd_valid) begin
          rd_rcv_next = rd_rcv_reg + 1'b1;
          to_cnt_next = '0;
          if (rd_rcv_reg == LAST_IDX) begin
            state_next   = ST_CHECK;
            chk_cyc_next = '0;
          end
        end else if (to_cnt_reg == TO_LAST) begin
          state_next   = ST_DONE;
          timeout_next = 1'b1;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      ST_CHECK: begin
        if (chk_cyc_reg == CHK_LAST) begin
          pass_cnt_next = pass_cnt_reg + 32'd1;
          base_next     = base_reg + ADDR_W'(BURST_WORDS);
          if (loop_reg && !(stop_reg || stop) && !(err_reg || err_set)) begin
            state_next    = ST_WRITE;
            wr_idx_next   = '0;
            fwd_cnt_next  = '0;
            qual_dly_next = '0;
          end else begin
            state_next = ST_DONE;
          end
        end else begin
          chk_cyc_next = chk_cyc_reg + 2'd1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      wr_idx_reg   <= '0;
      rd_cmd_reg   <= '0;
      rd_rcv_reg   <= '0;
      chk_cyc_reg  <= '0;
      to_cnt_reg   <= '0;
      fwd_cnt_reg  <= '0;
      qual_dly_reg <= '0;
      base_reg     <= '0;
      loop_reg     <= 1'b0;
      stop_reg     <= 1'b0;
      err_reg      <= 1'b0;
      timeout_reg  <= 1'b0;
      pass_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wr_idx_reg   <= wr_idx_next;
      rd_cmd_reg   <= rd_cmd_next;
      rd_rcv_reg   <= rd_rcv_next;
      chk_cyc_reg  <= chk_cyc_next;
      to_cnt_reg   <= to_cnt_next;
      fwd_cnt_reg  <= fwd_cnt_next;
      qual_dly_reg <= qual_dly_next;
      base_reg     <= base_next;
      loop_reg     <= loop_next;
      stop_reg     <= stop_next;
      err_reg      <= err_next;
      timeout_reg  <= timeout_next;
      pass_cnt_reg <= pass_cnt_next;
    end
  end

  // Read data only reaches the checker while the pass is still reading
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_wren_reg <= 1'b0;
      chk_data_reg <= '0;
    end else begin
      chk_wren_reg <= rd_take;
      chk_data_reg <= mem.rd_data;
    end
  end

  assign mem.wr_valid = (state_reg == ST_WRITE);
  assign mem.wr_addr  = base_reg + ADDR_W'(wr_idx_reg);
  assign mem.wr_data  = pattern_word;
  assign mem.rd_req   = rd_req_int;
  assign mem.rd_addr  = base_reg + ADDR_W'(rd_cmd_reg);

  assign chk_wren = chk_wren_reg;
  assign chk_data = chk_data_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign done     = (state_reg == ST_DONE);
  assign err      = err_reg;
  assign timeout  = timeout_reg;
  assign pass_cnt = pass_cnt_reg;

endmodule

// File: doc/sdram_stream_test_ctrl.md
Name: sdram_stream_test_ctrl

Overview:
Sequences the SDRAM stream test. Writes a burst of an incrementing 32-bit counter pattern into SDRAM as 16-bit words, reads the same burst back, and forwards the read data to the stream error checker. Collects the checker's error flag, counts passes and runs single-shot or continuous. Sits between the test host logic and the SDRAM controller's word-wide write and read ports.

Parameters:
BURST_WORDS, 256, 16-bit words per pass; must be a multiple of 4 and at least 4
ADDR_W, 22, SDRAM word-address width
TIMEOUT, 1024, idle cycles allowed with reads outstanding before a timeout abort

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  1-cycle pulse; begins a run when idle
loop  in  1  sampled at start; 1 = repeat passes until stop
stop  in  1  1-cycle pulse; finish current pass, then halt
wr_valid  out  1  write word valid
wr_ready  in  1  SDRAM write accept
wr_addr  out  ADDR_W  write word address
wr_data  out  16  write word
rd_req  out  1  read command valid
rd_ready  in  1  read command accept
rd_addr  out  ADDR_W  read word address
rd_valid  in  1  read data strobe
rd_data  in  16  read data word
chk_wren  out  1  checker write enable
chk_data  out  16  checker data
chk_err  in  1  checker error flag
busy  out  1  run in progress
done  out  1  1-cycle pulse at end of run
err  out  1  sticky data error
timeout  out  1  sticky read timeout
pass_cnt  out  32  completed passes

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; pattern counter 0; base address 0.
- FSM: IDLE -> WRITE on start. WRITE -> READ after BURST_WORDS accepted writes. READ -> CHECK after BURST_WORDS rd_valid words received. CHECK waits 2 cycles. CHECK -> WRITE if loop is latched, stop not seen and err clear; otherwise -> DONE. DONE -> IDLE after 1 cycle with done=1.
- busy=1 in every state except IDLE. A start pulse while busy is ignored. start and stop in the same IDLE cycle: start a single pass.
- Pattern: each 32-bit value is sent high half first, then low half; the value increments by 1 per word pair. The counter persists across passes and runs (it is not cleared on start) and wraps 0xFFFFFFFF -> 0.
- WRITE: wr_valid is held high. wr_addr, wr_data and the state do not change while wr_ready=0. On wr_valid&wr_ready, the address and word index advance.
- READ: issues rd_req with rd_addr = base + index, advancing on rd_ready, until BURST_WORDS commands are accepted. Received words are counted independently of commands. A read may be accepted in the same cycle as data returns.
- Checker path: chk_data <= rd_data and chk_wren <= rd_valid, 1-cycle registered latency. In all other states chk_wren=0.
- Error qualification: chk_err is ignored until 4 words of the current pass have been forwarded plus 2 cycles. After that, chk_err=1 in READ or CHECK sets err. err is sticky and cleared only on an accepted start.
- Timeout: in READ, a counter resets on each rd_valid and counts while words are outstanding. At TIMEOUT: set timeout, drop rd_req, go to DONE. Late rd_valid words are then ignored (no chk_wren).
- Pass end: at CHECK exit, increment pass_cnt (wraps) and add BURST_WORDS to base, mod 2^ADDR_W. Addresses wrap within a burst the same way. pass_cnt is cleared on an accepted start.
- An err detected in loop mode ends the run after the current pass.
- stop pulses are latched while busy and cleared in IDLE.
- rst mid-run: asynchronous return to reset values. wr_valid and rd_req drop immediately, and any in-flight read data is ignored.

Decomposition:
- Shared package: FSM state encoding (IDLE, WRITE, READ, CHECK, DONE), the 2-cycle checker latency constant, and the 4-word qualification constant.
- One natural sub-module: stream_pattern_gen (32-bit counter, high/low half select, advance enable, 16-bit word out).

Test Plan:
- start, loop=0, BURST_WORDS=8, wr_ready/rd_ready always 1, memory model echoes data with 3-cycle latency: writes 0000,0000,0000,0001,0000,0002,0000,0003 to addresses 0..7. chk_data carries the same sequence. done pulses once; pass_cnt=1; err=0.
- wr_ready toggles 1,0,0,1: wr_data and wr_addr stay stable during stalls; exactly 8 writes are accepted.
- Memory corrupts word 5 (0002 -> 0003) and the checker model asserts chk_err: err=1, done pulses, pass_cnt=1.
- loop=1, stop pulsed during pass 3: run ends after pass 3 with pass_cnt=3. Base addresses are 0, 8 and 16; pass 2 first word pair is 0000,0004.
- Memory never returns rd_valid, TIMEOUT=16: timeout=1 and done pulses 16 cycles after the last read data (or after entry into READ if none arrived); chk_wren stays 0.
- rst asserted mid-WRITE: outputs go to 0 asynchronously. A following start writes the pattern from 0000,0000 at address 0.
